// File: rtl/key_action_mapper.sv
// Maps the held PS/2 scancode onto NUM_KEYS action channels with per-channel
// press/release/level/toggle modes, enable gating and a shared auto-repeat timer.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | channel's key not held (or not yet evaluated)
// DOWN    | accepted press, key still held
// BLOCKED | key went down while channel disabled; ignored until released
module key_action_mapper #(
    parameter int NUM_KEYS        = 8,
    parameter int CLOCK_FREQUENCY = 25000000,
    parameter int REPEAT_DELAY    = CLOCK_FREQUENCY / 2,
    parameter int REPEAT_PERIOD   = CLOCK_FREQUENCY / 10
) (
    input  logic                      Clock,
    input  logic                      reset,
    input  logic [7:0]                kbData,
    input  logic [8*NUM_KEYS-1:0]     keyCodes,
    input  logic [2*NUM_KEYS-1:0]     keyMode,
    input  logic [NUM_KEYS-1:0]       keyEnable,
    input  logic [NUM_KEYS-1:0]       clearToggle,
    output logic [NUM_KEYS-1:0]       actions,
    output logic [NUM_KEYS-1:0]       repeatPulse,
    output logic                      anyPressed,
    output logic [$clog2(NUM_KEYS):0] activeKey
);

    localparam int AW = $clog2(NUM_KEYS) + 1;
    localparam int CW = $clog2(REPEAT_DELAY + 1);

    localparam logic [1:0] MODE_PRESS   = 2'b00;
    localparam logic [1:0] MODE_RELEASE = 2'b01;
    localparam logic [1:0] MODE_LEVEL   = 2'b10;
    localparam logic [1:0] MODE_TOGGLE  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_DOWN    = 2'b01,
        ST_BLOCKED = 2'b10
    } key_state_t;

    key_state_t          state   [NUM_KEYS];
    key_state_t          state_d [NUM_KEYS];
    logic [NUM_KEYS-1:0] toggle;
    logic [NUM_KEYS-1:0] toggle_d;
    logic [NUM_KEYS-1:0] actions_d;
    logic [NUM_KEYS-1:0] repeat_d;
    logic [NUM_KEYS-1:0] press;
    logic                any_d;
    logic [AW-1:0]       active_d;
    logic [CW-1:0]       rpt_cnt;
    logic [CW-1:0]       rpt_cnt_d;

    always_comb begin : next_state
        logic       taken;
        logic       matched;
        logic       released;
        logic [1:0] mode;
        logic [1:0] active_mode;
        int         active_idx;

        taken       = 1'b0;
        matched     = 1'b0;
        released    = 1'b0;
        mode        = MODE_PRESS;
        active_mode = MODE_PRESS;
        active_idx  = 0;
        press       = '0;
        toggle_d    = toggle;
        actions_d   = '0;
        repeat_d    = '0;
        any_d       = 1'b0;
        active_d    = '1;
        rpt_cnt_d   = rpt_cnt;

        for (int i = 0; i < NUM_KEYS; i++) begin
            matched    = (kbData == keyCodes[8*i +: 8]) && (keyCodes[8*i +: 8] != 8'h00);
            mode       = keyMode[2*i +: 2];
            released   = 1'b0;
            state_d[i] = state[i];
            case (state[i])
                ST_IDLE: begin
                    // a lower-indexed channel sharing the code claims it, whatever its state
                    if (matched && !taken) begin
                        state_d[i] = keyEnable[i] ? ST_DOWN : ST_BLOCKED;
                        press[i]   = keyEnable[i];
                    end
                end
                ST_DOWN: begin
                    if (!matched) begin
                        state_d[i] = ST_IDLE;
                        released   = 1'b1;
                    end
                end
                ST_BLOCKED: begin
                    if (!matched) state_d[i] = ST_IDLE;
                end
                default: state_d[i] = ST_IDLE;
            endcase
            taken = taken | matched;

            if (clearToggle[i])
                toggle_d[i] = 1'b0;
            else if (press[i] && mode == MODE_TOGGLE)
                toggle_d[i] = ~toggle[i];

            case (mode)
                MODE_PRESS:   actions_d[i] = press[i];
                MODE_RELEASE: actions_d[i] = released;
                MODE_LEVEL:   actions_d[i] = (state_d[i] == ST_DOWN);
                default:      actions_d[i] = toggle_d[i];
            endcase
        end

        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (state_d[i] == ST_DOWN) begin
                any_d       = 1'b1;
                active_d    = AW'(i);
                active_idx  = i;
                active_mode = keyMode[2*i +: 2];
            end
        end

        // zero means the timer is parked; it holds its value if the mode leaves press-pulse
        if (|press)
            rpt_cnt_d = CW'(REPEAT_DELAY);
        else if (!any_d)
            rpt_cnt_d = '0;
        else if (active_mode == MODE_PRESS && rpt_cnt != '0) begin
            if (rpt_cnt == CW'(1)) begin
                repeat_d[active_idx] = 1'b1;
                rpt_cnt_d            = CW'(REPEAT_PERIOD);
            end else begin
                rpt_cnt_d = rpt_cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_KEYS; i++) state[i] <= ST_IDLE;
            toggle      <= '0;
            actions     <= '0;
            repeatPulse <= '0;
            anyPressed  <= 1'b0;
            activeKey   <= '1;
            rpt_cnt     <= '0;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) state[i] <= state_d[i];
            toggle      <= toggle_d;
            actions     <= actions_d;
            repeatPulse <= repeat_d;
            anyPressed  <= any_d;
            activeKey   <= active_d;
            rpt_cnt     <= rpt_cnt_d;
        end
    end

endmodule

// File: tb/tb_key_action_mapper.sv
// Directed bench for key_action_mapper: stimulus pushes expected output changes,
// a monitor pops and compares them whenever the DUT's registered outputs change.
module tb_key_action_mapper;

    logic        Clock;
    logic        reset;
    logic [7:0]  kbData;
    logic [63:0] keyCodes;
    logic [15:0] keyMode;
    logic [7:0]  keyEnable;
    logic [7:0]  clearToggle;
    logic [7:0]  actions;
    logic [7:0]  repeatPulse;
    logic        anyPressed;
    logic [3:0]  activeKey;

    typedef struct {
        int          stamp;
        logic [20:0] obs;
    } ev_t;

    localparam logic [20:0] RST_OBS = {8'h00, 8'h00, 1'b0, 4'hF};

    ev_t sb[$];
    int  cyc     = 0;
    int  n_tests = 0;
    int  n_fail  = 0;
    int  t0;

    key_action_mapper #(
        .NUM_KEYS       (8),
        .CLOCK_FREQUENCY(25000000),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (4)
    ) dut (
        .Clock      (Clock),
        .reset      (reset),
        .kbData     (kbData),
        .keyCodes   (keyCodes),
        .keyMode    (keyMode),
        .keyEnable  (keyEnable),
        .clearToggle(clearToggle),
        .actions    (actions),
        .repeatPulse(repeatPulse),
        .anyPressed (anyPressed),
        .activeKey  (activeKey)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic expect_out(input int stamp, input logic [7:0] act, input logic [7:0] rep,
                              input logic any, input logic [3:0] key);
        ev_t e;
        e.stamp = stamp;
        e.obs   = {act, rep, any, key};
        sb.push_back(e);
    endtask

    task automatic set_key(input int ch, input logic [7:0] code, input logic [1:0] mode);
        keyCodes[8*ch +: 8] = code;
        keyMode[2*ch +: 2]  = mode;
    endtask

    task automatic check_now(input string name, input logic [20:0] act, input logic [20:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual act=%h rep=%h any=%b key=%h, required act=%h rep=%h any=%b key=%h",
                     name, act[20:13], act[12:5], act[4], act[3:0],
                     req[20:13], req[12:5], req[4], req[3:0]);
        end
    endtask

    // monitor: every change of the registered outputs must match the next queued expectation
    initial begin : monitor
        logic [20:0] prev;
        logic [20:0] obs;
        ev_t         e;
        prev = RST_OBS;
        forever begin
            @(negedge Clock);
            if (!reset) begin
                prev = RST_OBS;
            end else begin
                obs = {actions, repeatPulse, anyPressed, activeKey};
                if (obs !== prev) begin
                    n_tests++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_output cyc=%0d: actual act=%h rep=%h any=%b key=%h, required no change",
                                 cyc, obs[20:13], obs[12:5], obs[4], obs[3:0]);
                    end else begin
                        e = sb.pop_front();
                        if (e.stamp != cyc || e.obs !== obs) begin
                            n_fail++;
                            $display("FAIL output_event: actual cyc=%0d act=%h rep=%h any=%b key=%h, required cyc=%0d act=%h rep=%h any=%b key=%h",
                                     cyc, obs[20:13], obs[12:5], obs[4], obs[3:0],
                                     e.stamp, e.obs[20:13], e.obs[12:5], e.obs[4], e.obs[3:0]);
                        end
                    end
                    prev = obs;
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        n_fail++;
        $display("FAIL timeout: actual simulation still running, required finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        reset       = 1'b0;
        kbData      = 8'h00;
        keyCodes    = '0;
        keyMode     = '0;
        keyEnable   = 8'hFD;
        clearToggle = 8'h00;
        set_key(0, 8'h5A, 2'b00);
        set_key(1, 8'h16, 2'b00);
        set_key(2, 8'h76, 2'b11);
        set_key(3, 8'h29, 2'b00);
        tick(3);
        #1 check_now("reset_state", {actions, repeatPulse, anyPressed, activeKey}, RST_OBS);
        @(negedge Clock);
        reset = 1'b1;
        tick(2);

        // T1: press-pulse with repeats at +10, +14, +18 while held 20 cycles
        t0 = cyc;
        kbData = 8'h5A;
        expect_out(t0 + 1, 8'h01, 8'h00, 1'b1, 4'h0);
        expect_out(t0 + 2, 8'h00, 8'h00, 1'b1, 4'h0);
        for (int k = 0; k < 3; k++) begin
            expect_out(t0 + 11 + 4*k, 8'h00, 8'h01, 1'b1, 4'h0);
            expect_out(t0 + 12 + 4*k, 8'h00, 8'h00, 1'b1, 4'h0);
        end
        expect_out(t0 + 21, 8'h00, 8'h00, 1'b0, 4'hF);
        tick(20);
        kbData = 8'h00;
        tick(4);

        // T2: press while disabled stays blocked across the enable edge
        kbData = 8'h16;
        tick(5);
        keyEnable[1] = 1'b1;
        tick(3);
        kbData = 8'h00;
        tick(3);
        t0 = cyc;
        kbData = 8'h16;
        expect_out(t0 + 1, 8'h02, 8'h00, 1'b1, 4'h1);
        expect_out(t0 + 2, 8'h00, 8'h00, 1'b1, 4'h1);
        tick(4);
        kbData = 8'h00;
        expect_out(t0 + 5, 8'h00, 8'h00, 1'b0, 4'hF);
        tick(3);

        // T3: toggle 0 -> 1 -> 0, then clearToggle beats a simultaneous flip
        t0 = cyc;
        kbData = 8'h76;
        expect_out(t0 + 1, 8'h04, 8'h00, 1'b1, 4'h2);
        tick(3);
        kbData = 8'h00;
        expect_out(t0 + 4, 8'h04, 8'h00, 1'b0, 4'hF);
        tick(2);
        kbData = 8'h76;
        expect_out(t0 + 6, 8'h00, 8'h00, 1'b1, 4'h2);
        tick(3);
        kbData = 8'h00;
        expect_out(t0 + 9, 8'h00, 8'h00, 1'b0, 4'hF);
        tick(3);
        kbData = 8'h76;
        clearToggle = 8'h04;
        expect_out(t0 + 12, 8'h00, 8'h00, 1'b1, 4'h2);
        tick(1);
        clearToggle = 8'h00;
        tick(2);
        kbData = 8'h00;
        expect_out(t0 + 15, 8'h00, 8'h00, 1'b0, 4'hF);
        tick(3);

        // T4: repeat pulses at +10,+14,...,+30 after the press pulse, none after release
        t0 = cyc;
        kbData = 8'h29;
        expect_out(t0 + 1, 8'h08, 8'h00, 1'b1, 4'h3);
        expect_out(t0 + 2, 8'h00, 8'h00, 1'b1, 4'h3);
        for (int k = 0; k < 6; k++) begin
            expect_out(t0 + 11 + 4*k, 8'h00, 8'h08, 1'b1, 4'h3);
            if (k < 5) expect_out(t0 + 12 + 4*k, 8'h00, 8'h00, 1'b1, 4'h3);
        end
        expect_out(t0 + 32, 8'h00, 8'h00, 1'b0, 4'hF);
        tick(31);
        kbData = 8'h00;
        tick(12);

        // T5: direct 5A -> 59 switch releases ch0 and presses ch1 in one cycle
        set_key(0, 8'h5A, 2'b01);
        set_key(1, 8'h59, 2'b00);
        tick(1);
        t0 = cyc;
        kbData = 8'h5A;
        expect_out(t0 + 1, 8'h00, 8'h00, 1'b1, 4'h0);
        tick(3);
        kbData = 8'h59;
        expect_out(t0 + 4, 8'h03, 8'h00, 1'b1, 4'h1);
        expect_out(t0 + 5, 8'h00, 8'h00, 1'b1, 4'h1);
        tick(3);
        kbData = 8'h00;
        expect_out(t0 + 7, 8'h00, 8'h00, 1'b0, 4'hF);
        tick(3);

        // T6: asynchronous reset while a level channel is down
        set_key(0, 8'h5A, 2'b10);
        tick(1);
        t0 = cyc;
        kbData = 8'h5A;
        expect_out(t0 + 1, 8'h01, 8'h00, 1'b1, 4'h0);
        tick(3);
        #2 reset = 1'b0;
        #1 check_now("async_reset_clear", {actions, repeatPulse, anyPressed, activeKey}, RST_OBS);
        kbData = 8'h00;
        @(negedge Clock);
        reset = 1'b1;
        tick(8);

        // T7: shared scancode, lowest index wins
        set_key(4, 8'h5A, 2'b00);
        tick(1);
        t0 = cyc;
        kbData = 8'h5A;
        expect_out(t0 + 1, 8'h01, 8'h00, 1'b1, 4'h0);
        tick(3);
        kbData = 8'h00;
        expect_out(t0 + 4, 8'h00, 8'h00, 1'b0, 4'hF);
        tick(3);

        // T8: release pulse still fires after the enable drops
        set_key(4, 8'h00, 2'b00);
        set_key(0, 8'h5A, 2'b01);
        tick(1);
        t0 = cyc;
        kbData = 8'h5A;
        expect_out(t0 + 1, 8'h00, 8'h00, 1'b1, 4'h0);
        tick(2);
        keyEnable[0] = 1'b0;
        tick(1);
        kbData = 8'h00;
        expect_out(t0 + 4, 8'h01, 8'h00, 1'b0, 4'hF);
        expect_out(t0 + 5, 8'h00, 8'h00, 1'b0, 4'hF);
        tick(3);
        keyEnable[0] = 1'b1;
        tick(3);

        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drained: actual %0d pending events, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
